// File: rtl/mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mac_scheduler
// Description : Sequences one job of N back-to-back operations through the
//               SD4 MAC pipeline. Issues buffer reads, holds the exponent
//               bias for the job, tracks in-flight ops with a valid-tag
//               pipeline and collects results into a valid/ready FIFO.
//               Issue is credit-gated against FIFO space because the MAC
//               pipeline cannot stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_scheduler #(
    parameter int PIPE_LAT   = 5,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_ops,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [4:0]        exp_bias_cfg,
    output logic              busy,
    output logic              done,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_rd_addr,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    output logic [4:0]        mac_exp_bias,
    input  logic [15:0]       mac_out,
    output logic              out_valid,
    output logic [15:0]       out_data,
    input  logic              out_ready
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW:0] c_DEPTH = (c_CW+1)'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [CNT_W-1:0]  r_num_ops;
    logic [CNT_W-1:0]  r_issued;
    logic [ADDR_W-1:0] r_img_addr;
    logic [ADDR_W-1:0] r_wgt_addr;
    logic [4:0]        r_exp_bias;
    logic [PIPE_LAT:0] r_tags;
    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_inflight;
    logic [c_CW:0]     w_occupancy;
    logic              w_issue;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    // Count set tags: every op between issue and FIFO push holds one credit.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= PIPE_LAT; i++) begin
            w_inflight = w_inflight + c_CW'(r_tags[i]);
        end
    end

    assign w_occupancy = {1'b0, r_count} + {1'b0, w_inflight};
    assign w_issue     = (r_state == c_RUN) && (w_occupancy < c_DEPTH);
    assign w_accept    = (r_state == c_IDLE) && start;
    assign w_push      = r_tags[PIPE_LAT];
    assign w_pop       = (r_count != '0) && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state logic; RUN leaves on the edge issuing the last op.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = (num_ops == '0) ? c_DONE : c_RUN;
            c_RUN:   if (w_issue && (r_issued == r_num_ops - CNT_W'(1)))
                         w_next_state = c_DRAIN;
            c_DRAIN: if ((w_inflight == '0) && (r_count == '0))
                         w_next_state = c_DONE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Job configuration, latched only when a start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num_ops  <= '0;
            r_exp_bias <= '0;
        end else if (w_accept) begin
            r_num_ops  <= num_ops;
            r_exp_bias <= exp_bias_cfg;
        end
    end

    // Read addresses and issue counter; addresses wrap modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_img_addr <= '0;
            r_wgt_addr <= '0;
            r_issued   <= '0;
        end else if (w_accept) begin
            r_img_addr <= img_base;
            r_wgt_addr <= wgt_base;
            r_issued   <= '0;
        end else if (w_issue) begin
            r_img_addr <= r_img_addr + ADDR_W'(1);
            r_wgt_addr <= r_wgt_addr + ADDR_W'(1);
            r_issued   <= r_issued + CNT_W'(1);
        end
    end

    // Valid-tag shift register: one buffer-read cycle plus MAC latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tags <= '0;
        else      r_tags <= {r_tags[PIPE_LAT-1:0], w_issue};
    end

    // Result FIFO storage; written when a tag leaves the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= mac_out;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy         = (r_state != c_IDLE);
    assign done         = (r_state == c_DONE);
    assign img_rd_en    = w_issue;
    assign wgt_rd_en    = w_issue;
    assign img_rd_addr  = r_img_addr;
    assign wgt_rd_addr  = r_wgt_addr;
    assign mac_exp_bias = r_exp_bias;
    assign out_valid    = (r_count != '0);
    assign out_data     = r_mem[r_rd_ptr];

endmodule
`default_nettype wire
